// File: rtl/sl_preceptron_pkg.sv
// Shared constants and types for the single-layer perceptron datapath.
// The weight memory, MAC engine and host glue all pull their defaults from here
// so that a change of lane count or vector length happens in one place.
package sl_preceptron_pkg;

    localparam int DATA_IN_LANES  = 4;
    localparam int WEIGHTS_WIDTH  = 8;
    localparam int VECTOR_LENGTH  = 64;
    localparam int MEM_ADDR_WIDTH = 16;

    // Signed product is 2*W bits; summing VECTOR_LENGTH of them needs log2 more.
    localparam int SUM_WIDTH = 2 * WEIGHTS_WIDTH + $clog2(VECTOR_LENGTH);

    typedef logic [WEIGHTS_WIDTH-1:0] weight_t;

endpackage

// File: rtl/sl_load_tracker.sv
// Load-completeness tracker for the weight memory.
// Remembers which weight slots have been written at least once since the last
// reset or clear, so the MAC engine can tell when a full vector is present.
module sl_load_tracker #(
    parameter int VECTOR_LENGTH = 64,
    localparam int IDX_W = $clog2(VECTOR_LENGTH),
    localparam int CNT_W = $clog2(VECTOR_LENGTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_wrEn,
    input  logic [IDX_W-1:0] i_wrIdx,
    output logic [CNT_W-1:0] o_loadCount,
    output logic             o_loadDone
);

    logic [VECTOR_LENGTH-1:0] r_written;
    logic [CNT_W-1:0]         r_count;

    // Only the first write to a slot counts; rewrites leave the count alone.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_written <= '0;
            r_count   <= '0;
        end else if (i_wrEn && !r_written[i_wrIdx]) begin
            r_written[i_wrIdx] <= 1'b1;
            r_count            <= r_count + 1'b1;
        end
    end

    assign o_loadCount = r_count;
    assign o_loadDone  = (r_count == CNT_W'(VECTOR_LENGTH));

endmodule

// File: rtl/sl_weight_mem.sv
// Weight memory for the single-layer perceptron.
// A byte-wide host port loads and inspects weights; a wide engine port returns
// one lane group per request, lined up with a data_in beat. Both ports read the
// pre-edge contents, so a same-cycle write is only visible to later reads.
// The engine index is built by concatenation, so VECTOR_LENGTH/DATA_IN_LANES
// is expected to be a power of two.
module sl_weight_mem #(
    parameter int DATA_IN_LANES  = sl_preceptron_pkg::DATA_IN_LANES,
    parameter int MEM_ADDR_WIDTH = sl_preceptron_pkg::MEM_ADDR_WIDTH,
    parameter int WEIGHTS_WIDTH  = sl_preceptron_pkg::WEIGHTS_WIDTH,
    parameter int VECTOR_LENGTH  = sl_preceptron_pkg::VECTOR_LENGTH,
    localparam int GRP_W = $clog2(VECTOR_LENGTH / DATA_IN_LANES),
    localparam int CNT_W = $clog2(VECTOR_LENGTH + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   mem_wen,
    input  logic                                   mem_ren,
    input  logic [MEM_ADDR_WIDTH-1:0]              mem_addr,
    input  logic [WEIGHTS_WIDTH-1:0]               mem_wdata,
    output logic [WEIGHTS_WIDTH-1:0]               mem_rdata,
    output logic                                   mem_rvalid,
    output logic                                   mem_err,
    input  logic                                   mem_clear,
    input  logic                                   eng_req,
    input  logic [GRP_W-1:0]                       eng_grp,
    output logic [DATA_IN_LANES*WEIGHTS_WIDTH-1:0] eng_weights,
    output logic                                   eng_valid,
    output logic [CNT_W-1:0]                       load_count,
    output logic                                   load_done
);

    localparam int IDX_W  = $clog2(VECTOR_LENGTH);
    localparam int LANE_W = $clog2(DATA_IN_LANES);

    logic [WEIGHTS_WIDTH-1:0]               r_mem [VECTOR_LENGTH];
    logic [WEIGHTS_WIDTH-1:0]               r_rdata;
    logic                                   r_rvalid;
    logic                                   r_err;
    logic [DATA_IN_LANES*WEIGHTS_WIDTH-1:0] r_engWeights;
    logic                                   r_engValid;

    logic                                   w_inRange;
    logic [IDX_W-1:0]                       w_idx;
    logic                                   w_wrEn;
    logic                                   w_rdEn;
    logic [DATA_IN_LANES*WEIGHTS_WIDTH-1:0] w_engLanes;

    // The full address is compared so high bits never alias onto a real slot.
    assign w_inRange = (mem_addr < MEM_ADDR_WIDTH'(VECTOR_LENGTH));
    assign w_idx     = mem_addr[IDX_W-1:0];
    assign w_wrEn    = mem_wen & w_inRange & ~mem_clear;
    assign w_rdEn    = mem_ren & ~mem_wen & w_inRange;

    // Weight storage; clear outranks any write arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || mem_clear) begin
            for (int i = 0; i < VECTOR_LENGTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_mem[w_idx] <= mem_wdata;
        end
    end

    // Gather the lane group the engine asked for, lane k in the k-th slice.
    always_comb begin
        w_engLanes = '0;
        for (int k = 0; k < DATA_IN_LANES; k++) begin
            w_engLanes[k*WEIGHTS_WIDTH +: WEIGHTS_WIDTH] = r_mem[{eng_grp, LANE_W'(k)}];
        end
    end

    // Host read/error response, one cycle after the access; data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_rdEn;
            r_err    <= (mem_wen | mem_ren) & ~w_inRange;
            if (w_rdEn) begin
                r_rdata <= mem_clear ? '0 : r_mem[w_idx];
            end
        end
    end

    // Engine response, independent of the host port; data holds between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_engWeights <= '0;
            r_engValid   <= 1'b0;
        end else begin
            r_engValid <= eng_req;
            if (eng_req) begin
                r_engWeights <= mem_clear ? '0 : w_engLanes;
            end
        end
    end

    sl_load_tracker #(
        .VECTOR_LENGTH (VECTOR_LENGTH)
    ) u_loadTracker (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (mem_clear),
        .i_wrEn      (w_wrEn),
        .i_wrIdx     (w_idx),
        .o_loadCount (load_count),
        .o_loadDone  (load_done)
    );

    assign mem_rdata   = r_rdata;
    assign mem_rvalid  = r_rvalid;
    assign mem_err     = r_err;
    assign eng_weights = r_engWeights;
    assign eng_valid   = r_engValid;

endmodule
